// File: rtl/gmii2fifo9.sv
// GMII receive to 9-bit FIFO writer: optional preamble/SFD strip, per-frame
// {0,8'h00} terminators, clean truncation on overflow/error with frame/drop counters.
module gmii2fifo9 #(
   parameter bit          STRIP_PREAMBLE = 1'b1,
   parameter int unsigned GAP            = 4
) (
   input  logic        gmii_rx_clk,
   input  logic        sys_rst_n,
   input  logic        gmii_rx_dv,
   input  logic        gmii_rx_er,
   input  logic [7:0]  gmii_rxd,
   output logic        wr_clk,
   output logic [8:0]  din,
   output logic        wr_en,
   input  logic        full,
   output logic [15:0] frame_cnt,
   output logic [15:0] drop_cnt
);

   typedef enum logic [2:0] {IDLE, PRE, DATA, TRUNC, GAPW, DROP} state_t;

   localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
   localparam logic [7:0] PREAMBLE = 8'h55;
   localparam logic [7:0] SFD      = 8'hD5;

   state_t     state, state_n;
   logic       dv_d, er_d;
   logic [7:0] rxd_d;
   logic       rx_primed;
   logic [3:0] gap_cnt, gap_cnt_n;
   logic       dv_seen, dv_seen_n;
   logic [8:0] din_n;
   logic       wr_en_n;
   logic       frame_inc, drop_inc;

   assign wr_clk = gmii_rx_clk;

   // rx_primed blocks the reset value of dv_d from looking like an inter-frame gap,
   // so a frame already running at reset release stays in DROP.
   always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         dv_d      <= 1'b0;
         er_d      <= 1'b0;
         rxd_d     <= '0;
         rx_primed <= 1'b0;
      end else begin
         dv_d      <= gmii_rx_dv;
         er_d      <= gmii_rx_er;
         rxd_d     <= gmii_rxd;
         rx_primed <= 1'b1;
      end
   end

   always_comb begin
      state_n   = state;
      gap_cnt_n = gap_cnt;
      dv_seen_n = dv_seen;
      din_n     = '0;
      wr_en_n   = 1'b0;
      frame_inc = 1'b0;
      drop_inc  = 1'b0;
      case (state)
         IDLE: begin
            if (dv_d) begin
               if (STRIP_PREAMBLE) begin
                  if (rxd_d == PREAMBLE) begin
                     state_n = PRE;
                  end else if (rxd_d == SFD) begin
                     state_n = DATA;
                  end else begin
                     state_n  = DROP;
                     drop_inc = 1'b1;
                  end
               end else if (er_d || full) begin
                  state_n  = TRUNC;
                  drop_inc = 1'b1;
               end else begin
                  din_n   = {1'b1, rxd_d};
                  wr_en_n = 1'b1;
                  state_n = DATA;
               end
            end
         end
         PRE: begin
            if (!dv_d) begin
               state_n = IDLE;
            end else if (er_d) begin
               state_n  = DROP;
               drop_inc = 1'b1;
            end else if (rxd_d == SFD) begin
               state_n = DATA;
            end else if (rxd_d != PREAMBLE) begin
               state_n  = DROP;
               drop_inc = 1'b1;
            end
         end
         DATA: begin
            if (!dv_d) begin
               state_n   = GAPW;
               gap_cnt_n = '0;
               dv_seen_n = 1'b0;
            end else if (er_d || full) begin
               state_n  = TRUNC;
               drop_inc = 1'b1;
            end else begin
               din_n   = {1'b1, rxd_d};
               wr_en_n = 1'b1;
            end
         end
         TRUNC: begin
            if (!full) begin
               wr_en_n = 1'b1;
               state_n = DROP;
            end
         end
         GAPW: begin
            dv_seen_n = dv_seen | dv_d;
            if (!full) begin
               wr_en_n   = 1'b1;
               gap_cnt_n = gap_cnt + 4'd1;
               if (gap_cnt == GAP_LAST) begin
                  frame_inc = 1'b1;
                  if (dv_seen_n) begin
                     state_n  = DROP;
                     drop_inc = 1'b1;
                  end else begin
                     state_n = IDLE;
                  end
               end
            end
         end
         DROP: begin
            if (rx_primed && !dv_d) state_n = IDLE;
         end
         default: state_n = DROP;
      endcase
   end

   always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= DROP;
         gap_cnt   <= '0;
         dv_seen   <= 1'b0;
         din       <= '0;
         wr_en     <= 1'b0;
         frame_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         state   <= state_n;
         gap_cnt <= gap_cnt_n;
         dv_seen <= dv_seen_n;
         din     <= din_n;
         wr_en   <= wr_en_n;
         if (frame_inc) frame_cnt <= frame_cnt + 16'd1;
         if (drop_inc)  drop_cnt  <= drop_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_gmii2fifo9.sv
// Bench for gmii2fifo9: stripped and unstripped instances share one GMII stream;
// expected FIFO words go to per-instance queues, counters are checked per scenario.
module tb_gmii2fifo9;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        dv    = 1'b0;
   logic        er    = 1'b0;
   logic        full  = 1'b0;
   logic [7:0]  rxd   = 8'h00;

   logic        wrclk_s, wrclk_u;
   logic [8:0]  din_s, din_u;
   logic        wr_s, wr_u;
   logic [15:0] fc_s, dc_s, fc_u, dc_u;

   always #5 clk = ~clk;

   gmii2fifo9 #(.STRIP_PREAMBLE(1'b1), .GAP(4)) u_s (
      .gmii_rx_clk(clk), .sys_rst_n(rst_n), .gmii_rx_dv(dv), .gmii_rx_er(er),
      .gmii_rxd(rxd), .wr_clk(wrclk_s), .din(din_s), .wr_en(wr_s), .full(full),
      .frame_cnt(fc_s), .drop_cnt(dc_s));

   gmii2fifo9 #(.STRIP_PREAMBLE(1'b0), .GAP(4)) u_u (
      .gmii_rx_clk(clk), .sys_rst_n(rst_n), .gmii_rx_dv(dv), .gmii_rx_er(er),
      .gmii_rxd(rxd), .wr_clk(wrclk_u), .din(din_u), .wr_en(wr_u), .full(full),
      .frame_cnt(fc_u), .drop_cnt(dc_u));

   typedef struct {
      int         n_pre;
      logic [7:0] bad;
      bit         sfd;
      int         n_data;
      int         err_at;
      int         full_at;
      int         full_len;
      int         df_s;
      int         dd_s;
      int         df_u;
      int         dd_u;
   } row_t;

   row_t        rows[8];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          drive_cyc = -100;
   int          first_wr_cyc = -1;
   logic [8:0]  q_s[$];
   logic [8:0]  q_u[$];
   logic [8:0]  e_s, e_u;
   logic [15:0] ef_s = '0, ed_s = '0, ef_u = '0, ed_u = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && wr_s) begin
         if (q_s.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL s_unexpected_write: got din 0x%0h, expected no write", din_s);
         end else begin
            e_s = q_s.pop_front();
            check("s_din", {23'b0, din_s}, {23'b0, e_s});
            if (first_wr_cyc < 0 && din_s == 9'h100) first_wr_cyc = cyc;
         end
      end
      if (rst_n && wr_u) begin
         if (q_u.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL u_unexpected_write: got din 0x%0h, expected no write", din_u);
         end else begin
            e_u = q_u.pop_front();
            check("u_din", {23'b0, din_u}, {23'b0, e_u});
         end
      end
   end

   task automatic push_terms(input bit to_s, input bit trunc);
      int n;
      n = trunc ? 1 : 4;
      for (int i = 0; i < n; i++) begin
         if (to_s) q_s.push_back(9'h000);
         else      q_u.push_back(9'h000);
      end
   endtask

   task automatic check_end(input string pfx);
      check({pfx, "_frame_s"}, {16'b0, fc_s}, {16'b0, ef_s});
      check({pfx, "_drop_s"},  {16'b0, dc_s}, {16'b0, ed_s});
      check({pfx, "_frame_u"}, {16'b0, fc_u}, {16'b0, ef_u});
      check({pfx, "_drop_u"},  {16'b0, dc_u}, {16'b0, ed_u});
      check({pfx, "_s_words_left"}, q_s.size(), 0);
      check({pfx, "_u_words_left"}, q_u.size(), 0);
      q_s.delete();
      q_u.delete();
   endtask

   task automatic run_row(input int idx, input row_t r);
      logic [7:0] s[$];
      int data_off, err_pos, fs, fe, fault, p;
      for (int i = 0; i < r.n_pre; i++) s.push_back(8'h55);
      if (r.bad != 8'h00) s.push_back(r.bad);
      if (r.sfd) s.push_back(8'hD5);
      data_off = s.size();
      for (int i = 0; i < r.n_data; i++) s.push_back(8'(i));
      err_pos = (r.err_at < 0) ? -1 : data_off + r.err_at;
      fs      = (r.full_at < 0) ? -1 : data_off + r.full_at;
      fe      = fs + r.full_len;
      fault   = s.size();
      if (err_pos >= 0 && err_pos < fault) fault = err_pos;
      if (fs >= 0 && fs < fault) fault = fs;
      for (int i = 0; i < fault; i++) q_u.push_back({1'b1, s[i]});
      push_terms(1'b0, fault < s.size());
      p = 0;
      while (p < s.size() && s[p] == 8'h55) p++;
      if (p < s.size() && s[p] == 8'hD5) begin
         for (int i = p + 1; i < fault; i++) q_s.push_back({1'b1, s[i]});
         push_terms(1'b1, fault < s.size());
      end
      ef_s += 16'(r.df_s);
      ed_s += 16'(r.dd_s);
      ef_u += 16'(r.df_u);
      ed_u += 16'(r.dd_u);
      for (int t = 0; t < s.size() + 16; t++) begin
         @(negedge clk);
         if (t < s.size()) begin
            dv  = 1'b1;
            rxd = s[t];
         end else begin
            dv  = 1'b0;
            rxd = 8'h00;
         end
         er   = (t == err_pos);
         full = (fs >= 0) && (t - 1 >= fs) && (t - 1 < fe);
         if (idx == 0 && t == data_off) drive_cyc = cyc;
      end
      full = 1'b0;
      check_end($sformatf("row%0d", idx));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] gs[$];
      logic [7:0] s[$];

      //          pre bad    sfd  nd  err full len  fs ds fu du
      rows[0] = '{7, 8'h00, 1'b1, 64, -1, -1,  0,  1, 0, 1, 0}; // clean frame
      rows[1] = '{7, 8'h00, 1'b1, 64, -1, 10,  3,  0, 1, 0, 1}; // overflow on byte 10
      rows[2] = '{7, 8'h00, 1'b1, 64, 20, -1,  0,  0, 1, 0, 1}; // rx_er on byte 20
      rows[3] = '{3, 8'h00, 1'b0,  0, -1, -1,  0,  0, 0, 1, 0}; // dv falls in preamble
      rows[4] = '{2, 8'h12, 1'b0,  0, -1, -1,  0,  0, 1, 1, 0}; // bad preamble byte
      rows[5] = '{1, 8'h00, 1'b1,  1, -1, -1,  0,  1, 0, 1, 0}; // one-byte payload
      rows[6] = '{0, 8'h00, 1'b1,  3, -1, -1,  0,  1, 0, 1, 0}; // SFD without preamble
      rows[7] = '{7, 8'h00, 1'b1,  8, -1,  8,  3,  1, 0, 1, 0}; // full held during gap

      #2 rst_n = 1'b0;
      #1;
      check("rst_din_s",   {23'b0, din_s}, 0);
      check("rst_wr_en_s", {31'b0, wr_s},  0);
      check("rst_frame_s", {16'b0, fc_s},  0);
      check("rst_drop_s",  {16'b0, dc_s},  0);
      check("rst_wr_en_u", {31'b0, wr_u},  0);
      check("rst_drop_u",  {16'b0, dc_u},  0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_row(i, rows[i]);
         if (i == 0) check("first_write_latency", first_wr_cyc - drive_cyc, 2);
      end

      // second frame starts one cycle after the first ends: lands in GAPW -> DROP
      gs = {9'h1D5, 9'h100, 9'h101, 9'h102, 9'h103, 9'h000,
            9'h1D5, 9'h110, 9'h111, 9'h112, 9'h113};
      for (int i = 1; i < 5; i++) q_s.push_back(gs[i]);
      for (int i = 0; i < 5; i++) q_u.push_back(gs[i]);
      push_terms(1'b1, 1'b0);
      push_terms(1'b0, 1'b0);
      ef_s += 16'd1; ed_s += 16'd1; ef_u += 16'd1; ed_u += 16'd1;
      for (int t = 0; t < gs.size() + 16; t++) begin
         @(negedge clk);
         if (t < gs.size()) begin
            dv  = gs[t][8];
            rxd = gs[t][7:0];
         end else begin
            dv  = 1'b0;
            rxd = 8'h00;
         end
      end
      check_end("gap_overlap");

      // reset pulse in the middle of a frame, released while dv is still high
      for (int i = 0; i < 7; i++) s.push_back(8'h55);
      s.push_back(8'hD5);
      for (int i = 0; i < 64; i++) s.push_back(8'(i));
      for (int i = 0; i < 37; i++) q_u.push_back({1'b1, s[i]});
      for (int i = 8; i < 37; i++) q_s.push_back({1'b1, s[i]});
      for (int t = 0; t < s.size() + 16; t++) begin
         @(negedge clk);
         if (t < s.size()) begin
            dv  = 1'b1;
            rxd = s[t];
         end else begin
            dv  = 1'b0;
            rxd = 8'h00;
         end
         if (t == 38) begin
            #1 rst_n = 1'b0;
            #1;
            check("midrst_wr_en_s", {31'b0, wr_s}, 0);
            check("midrst_wr_en_u", {31'b0, wr_u}, 0);
            ef_s = '0; ed_s = '0; ef_u = '0; ed_u = '0;
         end
         if (t == 40) #1 rst_n = 1'b1;
      end
      check_end("midreset");
      run_row(100, rows[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
